// File: rtl/px_rect_fill_if.sv
// ---------------------------------------------------------------------------
// px_rect_fill_if
// Command channel for the rectangle filler: a valid/ready handshake carrying
// one fill request (position, size, colour, frame-sync flag).
//   cmd_valid  : requester offers a command
//   cmd_ready  : filler can accept a command
//   cmd_x      : left edge, pixels      (9 bits)
//   cmd_y      : top edge, lines        (8 bits)
//   cmd_w      : width, pixels          (9 bits)
//   cmd_h      : height, lines          (8 bits)
//   cmd_color  : R3G3B2 fill value      (8 bits)
//   cmd_sync   : wait for the next frameDrawn pulse before filling
// master = command source, slave = px_rect_fill.
// ---------------------------------------------------------------------------
interface px_rect_fill_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [8:0] cmd_x;
  logic [7:0] cmd_y;
  logic [8:0] cmd_w;
  logic [7:0] cmd_h;
  logic [7:0] cmd_color;
  logic       cmd_sync;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_sync,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_sync,
    output cmd_ready
  );
endinterface

// File: rtl/px_rect_fill.sv
// ---------------------------------------------------------------------------
// px_rect_fill
// Fills an axis-aligned rectangle of the pixel VRAM with a constant colour,
// one pixel per clock in raster order. Pixels outside the SCR_W x SCR_H plane
// are clipped (no write) but still take their cycle.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   cmd           : command channel (px_rect_fill_if.slave)
//   abort         : drop the current command (WAITSYNC/FILL only)
//   frameDrawn    : one-cycle end-of-frame pulse
//   vramPX_addr/d/we : VRAM write port (addr/data hold when not writing)
//   busy          : command in progress
//   done          : one-cycle completion pulse
// ---------------------------------------------------------------------------
module px_rect_fill #(
  parameter int SCR_W = 320,
  parameter int SCR_H = 240
) (
  input  logic              clk,
  input  logic              reset,
  px_rect_fill_if.slave     cmd,
  input  logic              abort,
  input  logic              frameDrawn,
  output logic [16:0]       vramPX_addr,
  output logic [7:0]        vramPX_d,
  output logic              vramPX_we,
  output logic              busy,
  output logic              done
);

  localparam logic [9:0]  SCR_W_L  = 10'(SCR_W);
  localparam logic [8:0]  SCR_H_L  = 9'(SCR_H);
  localparam logic [17:0] SCR_W_18 = 18'(SCR_W);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAITSYNC = 2'd1,
    S_FILL     = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  // y * SCR_W as a sum of shifted copies of y, one per set bit of SCR_W
  // (y<<8 + y<<6 for 320); SCR_W is constant so this folds to adders.
  function automatic logic [17:0] row_base(input logic [7:0] y);
    logic [17:0] acc;
    acc = 18'd0;
    for (int i = 0; i < 18; i++) begin
      if (SCR_W[i]) acc = acc + (18'(y) << i);
      else          acc = acc;
    end
    return acc;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [8:0]  r_x;
  logic [7:0]  r_color;
  logic [9:0]  r_col;        // current column, wide enough that x+w never wraps
  logic [8:0]  r_row;        // current row, wide enough that y+h never wraps
  logic [9:0]  r_col_last;
  logic [8:0]  r_row_last;
  logic [17:0] r_row_base;   // r_row * SCR_W, kept by repeated addition
  logic [16:0] r_addr_hold;
  logic [7:0]  r_d_hold;

  logic        w_accept;
  logic        w_row_end;
  logic        w_last_pix;
  logic        w_in_bounds;
  logic        w_we;
  logic [16:0] w_addr;

  // Handshake, position decode and write-port outputs.
  always_comb begin
    w_accept    = (r_state == S_IDLE) && cmd.cmd_valid;
    w_row_end   = (r_col == r_col_last);
    w_last_pix  = w_row_end && (r_row == r_row_last);
    w_in_bounds = (r_col < SCR_W_L) && (r_row < SCR_H_L);
    // abort suppresses the write in the very cycle it is seen
    w_we        = (r_state == S_FILL) && !abort && w_in_bounds;
    w_addr      = r_row_base[16:0] + {7'd0, r_col};
    cmd.cmd_ready = (r_state == S_IDLE);
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    vramPX_we   = w_we;
    if (w_we) begin
      vramPX_addr = w_addr;
      vramPX_d    = r_color;
    end else begin
      vramPX_addr = r_addr_hold;
      vramPX_d    = r_d_hold;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if ((cmd.cmd_w == 9'd0) || (cmd.cmd_h == 8'd0)) w_state_nxt = S_DONE;
          else if (cmd.cmd_sync)                           w_state_nxt = S_WAITSYNC;
          else                                             w_state_nxt = S_FILL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAITSYNC: begin
        if (abort)           w_state_nxt = S_IDLE;
        else if (frameDrawn) w_state_nxt = S_FILL;
        else                 w_state_nxt = S_WAITSYNC;
      end
      S_FILL: begin
        if (abort)           w_state_nxt = S_IDLE;
        else if (w_last_pix) w_state_nxt = S_DONE;
        else                 w_state_nxt = S_FILL;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Command capture and raster walk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x        <= 9'd0;
      r_color    <= 8'd0;
      r_col      <= 10'd0;
      r_row      <= 9'd0;
      r_col_last <= 10'd0;
      r_row_last <= 9'd0;
      r_row_base <= 18'd0;
    end else if (w_accept) begin
      r_x        <= cmd.cmd_x;
      r_color    <= cmd.cmd_color;
      r_col      <= {1'b0, cmd.cmd_x};
      r_row      <= {1'b0, cmd.cmd_y};
      // Only meaningful for non-empty rectangles; empty ones go to DONE.
      r_col_last <= {1'b0, cmd.cmd_x} + {1'b0, cmd.cmd_w} - 10'd1;
      r_row_last <= {1'b0, cmd.cmd_y} + {1'b0, cmd.cmd_h} - 9'd1;
      r_row_base <= row_base(cmd.cmd_y);
    end else if ((r_state == S_FILL) && !abort) begin
      if (w_row_end) begin
        r_col      <= {1'b0, r_x};
        r_row      <= r_row + 9'd1;
        r_row_base <= r_row_base + SCR_W_18;
      end else begin
        r_col      <= r_col + 10'd1;
      end
    end
  end

  // Last written address/data, presented while the port is idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr_hold <= 17'd0;
      r_d_hold    <= 8'd0;
    end else if (w_we) begin
      r_addr_hold <= w_addr;
      r_d_hold    <= r_color;
    end
  end

endmodule

// File: tb/tb_px_rect_fill.sv
// ---------------------------------------------------------------------------
// tb_px_rect_fill
// Directed bench for px_rect_fill. Writes and done pulses are logged with
// their cycle number on the falling edge; each test task compares the log
// against hand-computed addresses and cycles.
// ---------------------------------------------------------------------------
module tb_px_rect_fill;
  logic        clk = 1'b0;
  logic        reset;
  logic        abort;
  logic        frameDrawn;
  logic [16:0] vramPX_addr;
  logic [7:0]  vramPX_d;
  logic        vramPX_we;
  logic        busy;
  logic        done;

  px_rect_fill_if u_if ();

  px_rect_fill #(.SCR_W(320), .SCR_H(240)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (u_if),
    .abort       (abort),
    .frameDrawn  (frameDrawn),
    .vramPX_addr (vramPX_addr),
    .vramPX_d    (vramPX_d),
    .vramPX_we   (vramPX_we),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wr_cyc[$];
  logic [16:0] wr_addr[$];
  logic [7:0]  wr_d[$];
  int          done_cyc[$];

  always @(negedge clk) begin
    if (vramPX_we === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(vramPX_addr);
      wr_d.push_back(vramPX_d);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
  end

  int checks = 0;
  int errors = 0;

  task automatic clear_logs();
    wr_cyc.delete();
    wr_addr.delete();
    wr_d.delete();
    done_cyc.delete();
  endtask

  // Offer one command; t returns the acceptance cycle T (-1 on timeout).
  task automatic send_cmd(input logic [8:0] x, input logic [7:0] y,
                          input logic [8:0] w, input logic [7:0] h,
                          input logic [7:0] c, input logic s, input logic fd,
                          output int t);
    bit got;
    t = -1;
    got = 1'b0;
    @(posedge clk); #1;
    u_if.cmd_x = x; u_if.cmd_y = y; u_if.cmd_w = w; u_if.cmd_h = h;
    u_if.cmd_color = c; u_if.cmd_sync = s; u_if.cmd_valid = 1'b1;
    frameDrawn = fd;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (u_if.cmd_ready === 1'b1) begin
        t = cyc;
        got = 1'b1;
      end
    end
    @(posedge clk); #1;
    u_if.cmd_valid = 1'b0;
    frameDrawn = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept: cmd_ready never seen, expected acceptance within 20 cycles");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({u_if.cmd_ready, busy, done, vramPX_we} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: got ready/busy/done/we=%b expected 1000",
               {u_if.cmd_ready, busy, done, vramPX_we});
    end
    checks++;
    if (vramPX_addr !== 17'd0 || vramPX_d !== 8'd0) begin
      errors++;
      $display("FAIL reset_port: got addr=%0d d=%h expected addr=0 d=00", vramPX_addr, vramPX_d);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int t;
    int exp_a[6] = '{650, 651, 652, 970, 971, 972};
    clear_logs();
    send_cmd(9'd10, 8'd2, 9'd3, 8'd2, 8'hE3, 1'b0, 1'b0, t);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (wr_cyc.size() !== 6) begin
      errors++;
      $display("FAIL basic_count: got %0d writes expected 6", wr_cyc.size());
    end
    for (int i = 0; i < 6 && i < wr_cyc.size(); i++) begin
      checks++;
      if (wr_cyc[i] !== t + 1 + i || int'(wr_addr[i]) !== exp_a[i] || wr_d[i] !== 8'hE3) begin
        errors++;
        $display("FAIL basic_wr%0d: got cyc=%0d addr=%0d d=%h expected cyc=%0d addr=%0d d=e3",
                 i, wr_cyc[i], wr_addr[i], wr_d[i], t + 1 + i, exp_a[i]);
      end
    end
    checks++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== t + 7) begin
      errors++;
      $display("FAIL basic_done: got %0d pulses first at %0d expected 1 at %0d",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 7);
    end
    checks++;
    if (vramPX_addr !== 17'd972 || vramPX_d !== 8'hE3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold: got addr=%0d d=%h busy=%b expected addr=972 d=e3 busy=0",
               vramPX_addr, vramPX_d, busy);
    end
  endtask

  task automatic test_clip();
    int t;
    clear_logs();
    send_cmd(9'd318, 8'd239, 9'd4, 8'd2, 8'h1F, 1'b0, 1'b0, t);
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (wr_cyc.size() !== 2) begin
      errors++;
      $display("FAIL clip_count: got %0d writes expected 2", wr_cyc.size());
    end
    for (int i = 0; i < 2 && i < wr_cyc.size(); i++) begin
      checks++;
      if (wr_cyc[i] !== t + 1 + i || int'(wr_addr[i]) !== 76798 + i || wr_d[i] !== 8'h1F) begin
        errors++;
        $display("FAIL clip_wr%0d: got cyc=%0d addr=%0d d=%h expected cyc=%0d addr=%0d d=1f",
                 i, wr_cyc[i], wr_addr[i], wr_d[i], t + 1 + i, 76798 + i);
      end
    end
    checks++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== t + 9) begin
      errors++;
      $display("FAIL clip_done: got %0d pulses first at %0d expected 1 at %0d",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 9);
    end
  endtask

  task automatic test_zero();
    int t0;
    int t1;
    clear_logs();
    send_cmd(9'd5, 8'd5, 9'd0, 8'd3, 8'h33, 1'b0, 1'b0, t0);
    send_cmd(9'd5, 8'd5, 9'd4, 8'd0, 8'h33, 1'b0, 1'b0, t1);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (t1 !== t0 + 2) begin
      errors++;
      $display("FAIL zero_b2b: got second accept at %0d expected %0d", t1, t0 + 2);
    end
    checks++;
    if (wr_cyc.size() !== 0) begin
      errors++;
      $display("FAIL zero_writes: got %0d writes expected 0", wr_cyc.size());
    end
    checks++;
    if (done_cyc.size() !== 2 || done_cyc[0] !== t0 + 1 || done_cyc[1] !== t1 + 1) begin
      errors++;
      $display("FAIL zero_done: got %0d pulses first at %0d expected 2 at %0d and %0d",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t0 + 1, t1 + 1);
    end
  endtask

  task automatic test_sync();
    int t;
    clear_logs();
    send_cmd(9'd0, 8'd0, 9'd1, 8'd1, 8'h1C, 1'b1, 1'b1, t);
    for (int i = 0; i < 40 && cyc != t + 20; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b1 || u_if.cmd_ready !== 1'b0 || cyc !== t + 20) begin
      errors++;
      $display("FAIL sync_wait: got busy=%b ready=%b cyc=%0d expected busy=1 ready=0 cyc=%0d",
               busy, u_if.cmd_ready, cyc, t + 20);
    end
    frameDrawn = 1'b1;
    @(posedge clk); #1;
    frameDrawn = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (wr_cyc.size() !== 1 || wr_cyc[0] !== t + 21 || wr_addr[0] !== 17'd0) begin
      errors++;
      $display("FAIL sync_wr: got %0d writes first at %0d expected 1 at %0d addr 0",
               wr_cyc.size(), (wr_cyc.size() > 0) ? wr_cyc[0] : -1, t + 21);
    end
    checks++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== t + 22) begin
      errors++;
      $display("FAIL sync_done: got %0d pulses first at %0d expected 1 at %0d",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 22);
    end
  endtask

  task automatic test_abort();
    int t;
    clear_logs();
    send_cmd(9'd0, 8'd0, 9'd4, 8'd4, 8'h55, 1'b0, 1'b0, t);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    #1;
    checks++;
    if (vramPX_we !== 1'b0) begin
      errors++;
      $display("FAIL abort_we: got we=%b expected 0", vramPX_we);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || u_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b ready=%b expected busy=0 ready=1", busy, u_if.cmd_ready);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (wr_cyc.size() !== 2 || wr_addr[0] !== 17'd0 || wr_addr[1] !== 17'd1 || wr_cyc[1] !== t + 2) begin
      errors++;
      $display("FAIL abort_writes: got %0d writes expected 2 at addr 0,1 ending cycle %0d",
               wr_cyc.size(), t + 2);
    end
    checks++;
    if (done_cyc.size() !== 0) begin
      errors++;
      $display("FAIL abort_done: got %0d done pulses expected 0", done_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    int t;
    int t2;
    clear_logs();
    send_cmd(9'd0, 8'd0, 9'd4, 8'd4, 8'hAA, 1'b0, 1'b0, t);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    checks++;
    if (vramPX_we !== 1'b0 || busy !== 1'b0 || u_if.cmd_ready !== 1'b1 || vramPX_addr !== 17'd0) begin
      errors++;
      $display("FAIL rstmid_async: got we=%b busy=%b ready=%b addr=%0d expected we=0 busy=0 ready=1 addr=0",
               vramPX_we, busy, u_if.cmd_ready, vramPX_addr);
    end
    // new command presented as reset releases: first edge after release accepts it
    @(negedge clk);
    u_if.cmd_x = 9'd1; u_if.cmd_y = 8'd1; u_if.cmd_w = 9'd1; u_if.cmd_h = 8'd1;
    u_if.cmd_color = 8'h07; u_if.cmd_sync = 1'b0; u_if.cmd_valid = 1'b1;
    reset = 1'b0;
    t2 = cyc;
    @(posedge clk); #1;
    u_if.cmd_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (wr_cyc.size() !== 2 || wr_addr[0] !== 17'd0 || wr_cyc[0] !== t + 1) begin
      errors++;
      $display("FAIL rstmid_old: got %0d writes first at %0d expected 2 first at %0d addr 0",
               wr_cyc.size(), (wr_cyc.size() > 0) ? wr_cyc[0] : -1, t + 1);
    end
    checks++;
    if (wr_cyc.size() < 2 || wr_cyc[1] !== t2 + 1 || wr_addr[1] !== 17'd321 || wr_d[1] !== 8'h07) begin
      errors++;
      $display("FAIL rstmid_new: got %0d writes expected second at cycle %0d addr 321 d=07",
               wr_cyc.size(), t2 + 1);
    end
    checks++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== t2 + 2) begin
      errors++;
      $display("FAIL rstmid_done: got %0d pulses first at %0d expected 1 at %0d",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, t2 + 2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    abort = 1'b0;
    frameDrawn = 1'b0;
    u_if.cmd_valid = 1'b0;
    u_if.cmd_x = 9'd0;
    u_if.cmd_y = 8'd0;
    u_if.cmd_w = 9'd0;
    u_if.cmd_h = 8'd0;
    u_if.cmd_color = 8'd0;
    u_if.cmd_sync = 1'b0;
    test_reset();
    test_basic();
    test_clip();
    test_zero();
    test_sync();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
